// File: rtl/riscv_dmem_responder_pkg.sv
// Shared constants and helpers for the data-memory responder.
//   - MMIO window base default and register offsets inside the window
//   - error flag bit indices for err_o / STATUS
//   - mmioDecode(): maps a window offset to a register select plus a hit flag
package riscv_dmem_responder_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hFFFF;

  localparam logic [15:0] OFS_CYCLE   = 16'h0000;
  localparam logic [15:0] OFS_GPIO    = 16'h0004;
  localparam logic [15:0] OFS_STATUS  = 16'h0008;
  localparam logic [15:0] OFS_TIMECMP = 16'h000C;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_RANGE = 1;

  typedef enum logic [1:0] {
    REG_CYCLE   = 2'd0,
    REG_GPIO    = 2'd1,
    REG_STATUS  = 2'd2,
    REG_TIMECMP = 2'd3
  } mmioReg_e;

  typedef struct packed {
    logic     hit;
    mmioReg_e sel;
  } mmioDec_t;

  // TIMECMP always decodes as a hit, so with the timer compiled out a write
  // to it is silently dropped rather than flagged as a range error.
  function automatic mmioDec_t mmioDecode(input logic [15:0] offset);
    mmioDec_t dec;
    dec.hit = 1'b1;
    dec.sel = REG_CYCLE;
    unique case (offset)
      OFS_CYCLE:   dec.sel = REG_CYCLE;
      OFS_GPIO:    dec.sel = REG_GPIO;
      OFS_STATUS:  dec.sel = REG_STATUS;
      OFS_TIMECMP: dec.sel = REG_TIMECMP;
      default:     dec.hit = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/riscv_dmem_responder_mmio_regs.sv
// MMIO register block of the data-memory responder.
// Holds the free-running cycle counter, GPIO output register, sticky
// write-error STATUS (write-one-to-clear) and, when DMEM_TIMER_EN is
// defined, the TIMECMP register and the level timer interrupt.
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-low reset
//   wrEn          accepted write to a decoded register this cycle
//   regHit/regSel decoded register for the current address (read and write)
//   wdata         store data
//   newErr        error flags raised by the current access {range, align}
//   rdata         combinational read data of the selected register
//   gpio, err     registered GPIO and sticky error flags
//   irq           timer interrupt, 0 when DMEM_TIMER_EN is undefined
// Macro: DMEM_TIMER_EN enables TIMECMP and irq.
module riscv_dmem_responder_mmio_regs
  import riscv_dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wrEn,
  input  logic        regHit,
  input  mmioReg_e    regSel,
  input  logic [31:0] wdata,
  input  logic [1:0]  newErr,
  output logic [31:0] rdata,
  output logic [31:0] gpio,
  output logic [1:0]  err,
  output logic        irq
);

  logic [31:0] cycle;
  logic [31:0] timecmpRd;
  logic [1:0]  errClr;
  logic [1:0]  errNext;

  // A write to CYCLE takes priority over the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= 32'd0;
    end else if (wrEn && regSel == REG_CYCLE) begin
      cycle <= wdata;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio <= 32'd0;
    end else if (wrEn && regSel == REG_GPIO) begin
      gpio <= wdata;
    end
  end

  // Clear first, then OR in new errors so a fresh error survives a
  // simultaneous clear of the same bit.
  always_comb begin
    errClr  = (wrEn && regSel == REG_STATUS) ? wdata[1:0] : 2'b00;
    errNext = (err & ~errClr) | newErr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 2'b00;
    end else begin
      err <= errNext;
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] timecmp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timecmp <= 32'hFFFF_FFFF;
    end else if (wrEn && regSel == REG_TIMECMP) begin
      timecmp <= wdata;
    end
  end

  // Compares the registered values, so irq lags the counter by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (cycle >= timecmp);
    end
  end

  assign timecmpRd = timecmp;
`else
  assign irq       = 1'b0;
  assign timecmpRd = 32'd0;
`endif

  always_comb begin
    rdata = 32'd0;
    if (regHit) begin
      unique case (regSel)
        REG_CYCLE:   rdata = cycle;
        REG_GPIO:    rdata = gpio;
        REG_STATUS:  rdata = {30'd0, err};
        REG_TIMECMP: rdata = timecmpRd;
        default:     rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the core's M-stage interface.
// Word RAM with combinational read and edge-triggered write, plus an MMIO
// window (cycle counter, GPIO, sticky error STATUS, optional TIMECMP).
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   addr_i   byte address (ALUResultM)
//   wdata_i  store data (WriteDataM)
//   we_i     store strobe (MemWriteM)
//   rdata_o  load data, combinational from addr_i
//   gpio_o   GPIO register
//   err_o    sticky error flags {range_err, align_err}
//   irq_o    timer interrupt (0 unless DMEM_TIMER_EN)
// Macro: DMEM_TIMER_EN enables the TIMECMP register and irq_o.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  output logic [31:0] gpio_o,
  output logic [1:0]  err_o,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];

  logic          isMmio;
  logic          isRam;
  logic          aligned;
  logic [AW-1:0] wordIdx;
  mmioDec_t      mmioDec;
  logic          ramWe;
  logic          mmioWe;
  logic [1:0]    newErr;
  logic [31:0]   mmioRdata;

  // Address decode. The MMIO window sits far above any legal RAM size, so
  // the two regions never overlap; MMIO is still tested first for clarity.
  always_comb begin
    isMmio  = (addr_i[31:16] == MMIO_BASE);
    isRam   = !isMmio && (addr_i[31:AW+2] == '0);
    aligned = (addr_i[1:0] == 2'b00);
    wordIdx = addr_i[AW+1:2];
    mmioDec = mmioDecode(addr_i[15:0]);
  end

  // Only stores raise errors; alignment is checked ahead of range.
  always_comb begin
    ramWe             = we_i && aligned && isRam;
    mmioWe            = we_i && aligned && isMmio && mmioDec.hit;
    newErr            = 2'b00;
    newErr[ERR_ALIGN] = we_i && !aligned;
    newErr[ERR_RANGE] = we_i && aligned && !isRam && !(isMmio && mmioDec.hit);
  end

  // RAM contents are never reset; gating on reset drops a store that
  // coincides with an asserted reset.
  always_ff @(posedge clk) begin
    if (reset && ramWe) begin
      mem[wordIdx] <= wdata_i;
    end
  end

  riscv_dmem_responder_mmio_regs uMmio (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (mmioWe),
    .regHit (isMmio && mmioDec.hit),
    .regSel (mmioDec.sel),
    .wdata  (wdata_i),
    .newErr (newErr),
    .rdata  (mmioRdata),
    .gpio   (gpio_o),
    .err    (err_o),
    .irq    (irq_o)
  );

  // Read-during-write returns the old word because the array only updates
  // on the clock edge.
  always_comb begin
    rdata_o = 32'd0;
    if (isMmio) begin
      rdata_o = mmioRdata;
    end else if (isRam) begin
      rdata_o = mem[wordIdx];
    end
  end

endmodule
